// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and FSM state encoding.
package alu_multicycle_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_MUL  = 4'd8,
    OP_BEQ  = 4'd9,
    OP_BNE  = 4'd10,
    OP_BLT  = 4'd11,
    OP_BGE  = 4'd12,
    OP_BLTU = 4'd13,
    OP_BGEU = 4'd14,
    OP_ZERO = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_multicycle_if.sv
// Operation/result handshake bundle between the ID/EX stage and the multi-cycle ALU.
interface alu_multicycle_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_in_1;
  logic [XLEN-1:0] alu_in_2;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            alu_bcond;

  modport master (
    output in_valid, alu_op, alu_in_1, alu_in_2, kill, out_ready,
    input  in_ready, out_valid, alu_result, alu_bcond
  );

  modport slave (
    input  in_valid, alu_op, alu_in_1, alu_in_2, kill, out_ready,
    output in_ready, out_valid, alu_result, alu_bcond
  );
endinterface

// File: rtl/alu_multicycle_comb.sv
// Single-cycle datapath: logic/arithmetic ops, branch compares and ZERO.
// Shift and multiply codes produce 0 here; the top handles them iteratively.
module alu_comb_unit
  import alu_multicycle_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            bcond
);

  // Decode the operation into a result word and a branch flag.
  always_comb begin
    result = {XLEN{1'b0}};
    bcond  = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_BEQ:  bcond  = (a == b);
      OP_BNE:  bcond  = (a != b);
      OP_BLT:  bcond  = ($signed(a) <  $signed(b));
      OP_BGE:  bcond  = ($signed(a) >= $signed(b));
      OP_BLTU: bcond  = (a <  b);
      OP_BGEU: bcond  = (a >= b);
      default: begin
        result = {XLEN{1'b0}};
        bcond  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle ops finish in one cycle, shifts step one bit per
// cycle and MUL runs shift-add until the multiplier is exhausted.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              reset,
  alu_multicycle_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_r;
  alu_op_e         op_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [XLEN-1:0] result_r;
  logic            bcond_r;
  logic [XLEN-1:0] shval_r;
  logic [SHW-1:0]  cnt_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] mcand_r;
  logic [XLEN-1:0] mplier_r;

  alu_op_e         in_op_s;
  logic [SHW-1:0]  shamt_s;
  logic [XLEN-1:0] comb_result_s;
  logic            comb_bcond_s;
  logic [XLEN-1:0] shift_next_s;
  logic [XLEN-1:0] acc_next_s;
  logic [XLEN-1:0] mplier_next_s;

  assign in_op_s = alu_op_e'(bus.alu_op);
  assign shamt_s = bus.alu_in_2[SHW-1:0];

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.alu_result = result_r;
  assign bus.alu_bcond  = bcond_r;

  alu_comb_unit #(.XLEN(XLEN)) u_comb (
    .op     (in_op_s),
    .a      (bus.alu_in_1),
    .b      (bus.alu_in_2),
    .result (comb_result_s),
    .bcond  (comb_bcond_s)
  );

  // One-bit step of the latched shift; SRA replicates the current sign bit.
  always_comb begin
    shift_next_s = shval_r;
    case (op_r)
      OP_SLL:  shift_next_s = {shval_r[XLEN-2:0], 1'b0};
      OP_SRL:  shift_next_s = {1'b0, shval_r[XLEN-1:1]};
      OP_SRA:  shift_next_s = {shval_r[XLEN-1], shval_r[XLEN-1:1]};
      default: shift_next_s = shval_r;
    endcase
  end

  // One shift-add step of the multiplier.
  always_comb begin
    mplier_next_s = {1'b0, mplier_r[XLEN-1:1]};
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Control FSM with registered handshake outputs, result and iteration state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_ADD;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      bcond_r     <= 1'b0;
      shval_r     <= {XLEN{1'b0}};
      cnt_r       <= {SHW{1'b0}};
      acc_r       <= {XLEN{1'b0}};
      mcand_r     <= {XLEN{1'b0}};
      mplier_r    <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          // kill wins over a simultaneous offer
          if (!bus.kill && bus.in_valid) begin
            op_r       <= in_op_s;
            in_ready_r <= 1'b0;
            case (in_op_s)
              OP_SLL, OP_SRL, OP_SRA: begin
                if (shamt_s == {SHW{1'b0}}) begin
                  result_r    <= bus.alu_in_1;
                  bcond_r     <= 1'b0;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
                end else begin
                  shval_r <= bus.alu_in_1;
                  cnt_r   <= shamt_s;
                  state_r <= ST_BUSY;
                end
              end
              OP_MUL: begin
                if (bus.alu_in_2 == {XLEN{1'b0}}) begin
                  result_r    <= {XLEN{1'b0}};
                  bcond_r     <= 1'b0;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
                end else begin
                  acc_r    <= {XLEN{1'b0}};
                  mcand_r  <= bus.alu_in_1;
                  mplier_r <= bus.alu_in_2;
                  state_r  <= ST_BUSY;
                end
              end
              default: begin
                result_r    <= comb_result_s;
                bcond_r     <= comb_bcond_s;
                out_valid_r <= 1'b1;
                state_r     <= ST_DONE;
              end
            endcase
          end
        end
        ST_BUSY: begin
          if (bus.kill) begin
            in_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end else if (op_r == OP_MUL) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
            mplier_r <= mplier_next_s;
            if (mplier_next_s == {XLEN{1'b0}}) begin
              result_r    <= acc_next_s;
              bcond_r     <= 1'b0;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end else begin
            shval_r <= shift_next_s;
            cnt_r   <= cnt_r - SHW'(1);
            if (cnt_r == SHW'(1)) begin
              result_r    <= shift_next_s;
              bcond_r     <= 1'b0;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // result/bcond stay put; only the handshake flags change
          if (bus.kill || bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed plus randomized bench for alu_multicycle against a plain-arithmetic model.
module tb_alu_multicycle;
  localparam int XLEN = 32;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  alu_multicycle_if #(.XLEN(XLEN)) bus ();

  alu_multicycle #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] k;
    k = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << k;
      4'd6:    return a >> k;
      4'd7:    return $unsigned($signed(a) >>> k);
      4'd8:    return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_bc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd9:    return a == b;
      4'd10:   return a != b;
      4'd11:   return $signed(a) <  $signed(b);
      4'd12:   return $signed(a) >= $signed(b);
      4'd13:   return a <  b;
      4'd14:   return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_lat(input logic [3:0] op, input logic [31:0] b);
    int hi;
    if (op >= 4'd5 && op <= 4'd7) return int'(b[4:0]) + 1;
    if (op == 4'd8) begin
      if (b == 32'd0) return 1;
      hi = 0;
      for (int i = 0; i < 32; i++) if (b[i]) hi = i;
      return hi + 2;
    end
    return 1;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, offers one op and leaves the bench one cycle after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 64) begin
      tick();
      w++;
    end
    check("issue_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.alu_in_1 = a;
    bus.alu_in_2 = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Counts cycles to out_valid (1 = first cycle after accept) and checks the result.
  task automatic await_done(input string tag, input int lat_exp, input logic [31:0] res_exp, input logic bc_exp);
    int lat;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    check({tag, "_res"}, {32'd0, bus.alu_result}, {32'd0, res_exp});
    check({tag, "_bc"}, {63'd0, bus.alu_bcond}, {63'd0, bc_exp});
  endtask

  // Full transaction with out_ready high; checks in_ready returns after DONE.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    await_done(tag, m_lat(op, b), m_res(op, a, b), m_bc(op, a, b));
    tick();
    check({tag, "_rdy_back"}, {63'd0, bus.in_ready}, 64'd1);
    check({tag, "_ov_low"}, {63'd0, bus.out_valid}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_op    = 4'd0;
    bus.alu_in_1  = 32'd0;
    bus.alu_in_2  = 32'd0;
    bus.kill      = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_result", {32'd0, bus.alu_result}, 64'd0);
    check("rst_bcond", {63'd0, bus.alu_bcond}, 64'd0);
    reset = 1'b0;
    tick();

    // Directed single-cycle ops and compares
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
    run_op("bltu", 4'd13, 32'd1, 32'hFFFF_FFFF);
    run_op("blt", 4'd11, 32'd1, 32'hFFFF_FFFF);
    run_op("sub", 4'd1, 32'd5, 32'd7);
    run_op("zero", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0);

    // Shifts
    run_op("sra_k3", 4'd7, 32'h8000_0000, 32'h0000_0023);
    run_op("sll_k0", 4'd5, 32'hDEAD_BEEF, 32'h0000_0020);
    run_op("srl_k31", 4'd6, 32'h8000_0000, 32'd31);

    // Multiply
    run_op("mul_small", 4'd8, 32'd12345, 32'd6789);
    run_op("mul_ones", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_b0", 4'd8, 32'd99, 32'd0);
    check("mul_const", {32'd0, m_res(4'd8, 32'd12345, 32'd6789)}, 64'h04FE_D79D);

    // Backpressure: hold result, in_valid held, no second accept
    bus.out_ready = 1'b0;
    issue(4'd2, 32'hF0F0_1234, 32'hFF00_FF00);
    await_done("bp", 1, 32'hF000_1200, 1'b0);
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'd0;
    bus.alu_in_1 = 32'd1;
    bus.alu_in_2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_res", {32'd0, bus.alu_result}, 64'hF000_1200);
      check("bp_hold_ov", {63'd0, bus.out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_rdy_back", {63'd0, bus.in_ready}, 64'd1);
    check("bp_ov_drop", {63'd0, bus.out_valid}, 64'd0);

    // kill during MUL
    issue(4'd8, 32'd3, 32'h100);
    tick();
    tick();
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    check("kill_idle", {63'd0, bus.in_ready}, 64'd1);
    check("kill_keep_res", {32'd0, bus.alu_result}, 64'hF000_1200);
    for (int i = 0; i < 12; i++) begin
      check("kill_no_ov", {63'd0, bus.out_valid}, 64'd0);
      tick();
    end
    run_op("xor_after_kill", 4'd4, 32'h0000_00F0, 32'h0000_00FF);
    check("xor_const", {32'd0, m_res(4'd4, 32'hF0, 32'hFF)}, 64'h0F);

    // kill in IDLE beats in_valid
    bus.kill     = 1'b1;
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'd3;
    bus.alu_in_1 = 32'h1;
    bus.alu_in_2 = 32'h2;
    tick();
    bus.kill     = 1'b0;
    bus.in_valid = 1'b0;
    check("kill_pri_ov", {63'd0, bus.out_valid}, 64'd0);
    check("kill_pri_rdy", {63'd0, bus.in_ready}, 64'd1);

    // kill in DONE while stalled
    bus.out_ready = 1'b0;
    issue(4'd0, 32'd10, 32'd20);
    await_done("kd", 1, 32'd30, 1'b0);
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    bus.out_ready = 1'b1;
    check("kd_ov", {63'd0, bus.out_valid}, 64'd0);
    check("kd_res_kept", {32'd0, bus.alu_result}, 64'd30);

    // Randomized ops against the model
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (n % 4 == 0) rb = rb & 32'h0000_00FF;
      if (n % 7 == 0) ra = rb;
      run_op("rand", rop, ra, rb);
    end

    // Reset in the middle of a MUL
    run_op("pre_rst_add", 4'd0, 32'd100, 32'd23);
    issue(4'd8, 32'd7, 32'h8000_0000);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst_mid_ov", {63'd0, bus.out_valid}, 64'd0);
    check("rst_mid_rdy", {63'd0, bus.in_ready}, 64'd1);
    held = bus.alu_result;
    check("rst_mid_res", {32'd0, held}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_rel_rdy", {63'd0, bus.in_ready}, 64'd1);
    check("rst_rel_res", {32'd0, bus.alu_result}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      check("rst_no_ov", {63'd0, bus.out_valid}, 64'd0);
      tick();
    end
    run_op("post_rst_mul", 4'd8, 32'd7, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, handshaked successor to the single-cycle ALU.
- Adds variable-amount shifts (iterative, 1 bit/cycle), low-half multiply (iterative shift-add with early termination) and unsigned branch compares.
- Takes one operation at a time through valid/ready in and out, so the CPU datapath can stall on multi-cycle ops.
- Sits between the ID/EX operand latches and the writeback/branch logic.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8
- SHW, $clog2(XLEN), derived; shift-amount width taken from in_2[SHW-1:0]

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation
- alu_op  in  4  operation code (codes below)
- alu_in_1  in  XLEN  operand A
- alu_in_2  in  XLEN  operand B / shift amount / multiplier
- kill  in  1  synchronous abort of an in-flight op
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- alu_result  out  XLEN  result
- alu_bcond  out  1  branch condition; 0 for non-branch ops

Behaviour:
- Reset is asynchronous and active-high; one clock domain. On reset:
  - state=IDLE, in_ready=1, out_valid=0
  - alu_result=0, alu_bcond=0, all internal registers 0
  - reset mid-operation discards the op with no output.
- Op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, MUL 8, BEQ 9, BNE 10, BLT 11 (signed), BGE 12 (signed), BLTU 13, BGEU 14, ZERO 15.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready at a rising edge latches op and operands.
- Single-cycle ops (0-4, 9-15):
  - result computed at the accept edge; IDLE -> DONE.
  - out_valid high in the first cycle after accept (latency 1).
  - Branch ops: alu_result=0, alu_bcond=compare. All other ops: alu_bcond=0.
  - ZERO: result 0.
- Shifts (5-7), k = alu_in_2[SHW-1:0] (upper bits ignored):
  - k=0: IDLE -> DONE with result = alu_in_1 (latency 1).
  - else IDLE -> BUSY; each BUSY cycle shifts by 1 and decrements the count; on count reaching 0 -> DONE.
  - out_valid rises k+1 cycles after accept.
  - SRA replicates bit XLEN-1 of the current value; SRL/SLL fill with 0.
- MUL (8):
  - Registers: acc=0, mcand=A, mplier=B.
  - Each BUSY cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1 (logical).
  - -> DONE once the updated mplier == 0.
  - B=0: IDLE -> DONE directly, result 0 (latency 1).
  - Otherwise latency = (index of B's highest set bit)+2; maximum XLEN+1.
  - Result = low XLEN bits of A*B; signed and unsigned give identical bits.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN; no carry or overflow outputs.
- DONE: alu_result/alu_bcond held stable while out_valid & !out_ready. On out_ready -> IDLE; in_ready rises the next cycle (no same-cycle back-to-back accept).
- kill:
  - In BUSY or DONE: -> IDLE next edge, out_valid=0, result discarded; alu_result/alu_bcond keep their last value.
  - In IDLE, kill has priority over in_valid (no accept).
- out_ready outside DONE is ignored. in_valid outside IDLE is ignored; the source must hold it.

Decomposition:
- Shared header alu_func.v extends the existing op-code defines to the 16 codes above.
- Shared header also holds the state encoding (IDLE/BUSY/DONE).
- One sub-module: alu_comb_unit, the combinational ADD..XOR, compare and ZERO datapath, parameter XLEN.
- The FSM, shift counter and multiply registers stay in alu_multicycle.

Test Plan:
- Reset asserted mid-MUL (A=7, B=0x8000_0000): out_valid=0 immediately; after release, in_ready=1 and alu_result=0.
- ADD A=0xFFFF_FFFF, B=1, out_ready=1: out_valid 1 cycle after accept, result 0, bcond 0. BLTU A=1, B=0xFFFF_FFFF: bcond=1. BLT same operands: bcond=0.
- SRA A=0x8000_0000, B=0x0000_0023 (k=3): out_valid exactly 4 cycles after accept, result 0xF000_0000. SLL with k=0: latency 1, result=A.
- MUL A=12345, B=6789: result 83810205 (0x04FE_D79D), latency 14. MUL A=0xFFFF_FFFF, B=0xFFFF_FFFF: result 1, latency 33.
- Backpressure: out_ready=0 for 5 cycles after DONE, with in_valid held: result stable, in_ready=0, no second accept. Then out_ready=1: in_ready back 1 cycle later.
- kill 3 cycles into MUL A=3, B=0x100: no out_valid. Next op, XOR 0xF0 ^ 0xFF, yields 0x0F.
